// File: rtl/fifo_ctrl_tpram_if.sv
// Bus bundle for fifo_ctrl_tpram: write/read handshake, data, pointers and flags.
// The FIFO_ERR_FLAGS_EN macro adds the sticky overflow/underflow outputs.
interface fifo_ctrl_tpram_if #(
  parameter int ADDR_LENGTH = 5,
  parameter int DATA_WIDTH  = 32
);
  logic                   clear_in;
  logic                   wenable_in;
  logic [DATA_WIDTH-1:0]  wdata_in;
  logic                   renable_in;
  logic [DATA_WIDTH-1:0]  rdata_out;
  logic                   wallow_out;
  logic                   rallow_out;
  logic [ADDR_LENGTH-1:0] waddr_out;
  logic [ADDR_LENGTH-1:0] raddr_out;
  logic                   full_out;
  logic                   almost_full_out;
  logic                   empty_out;
  logic                   almost_empty_out;
  logic                   half_full_out;
  logic                   three_left_out;
  logic                   two_left_out;
`ifdef FIFO_ERR_FLAGS_EN
  logic                   overflow_out;
  logic                   underflow_out;

  modport slave (
    input  clear_in, wenable_in, wdata_in, renable_in,
    output rdata_out, wallow_out, rallow_out, waddr_out, raddr_out,
           full_out, almost_full_out, empty_out, almost_empty_out,
           half_full_out, three_left_out, two_left_out,
           overflow_out, underflow_out
  );
  modport master (
    output clear_in, wenable_in, wdata_in, renable_in,
    input  rdata_out, wallow_out, rallow_out, waddr_out, raddr_out,
           full_out, almost_full_out, empty_out, almost_empty_out,
           half_full_out, three_left_out, two_left_out,
           overflow_out, underflow_out
  );
`else
  modport slave (
    input  clear_in, wenable_in, wdata_in, renable_in,
    output rdata_out, wallow_out, rallow_out, waddr_out, raddr_out,
           full_out, almost_full_out, empty_out, almost_empty_out,
           half_full_out, three_left_out, two_left_out
  );
  modport master (
    output clear_in, wenable_in, wdata_in, renable_in,
    input  rdata_out, wallow_out, rallow_out, waddr_out, raddr_out,
           full_out, almost_full_out, empty_out, almost_empty_out,
           half_full_out, three_left_out, two_left_out
  );
`endif
endinterface

// File: rtl/fifo_ctrl_tpram.sv
// Single-clock first-word-fall-through FIFO: count-based flags over a two-port RAM.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow_out / underflow_out.
module fifo_ctrl_tpram #(
  parameter int ADDR_LENGTH = 5,
  parameter int DATA_WIDTH  = 32
) (
  input logic              CLK,
  input logic              reset_n,
  fifo_ctrl_tpram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_LENGTH;
  localparam logic [ADDR_LENGTH:0] C_FULL = (ADDR_LENGTH+1)'(DEPTH);
  localparam logic [ADDR_LENGTH:0] C_M1   = (ADDR_LENGTH+1)'(DEPTH - 1);
  localparam logic [ADDR_LENGTH:0] C_M2   = (ADDR_LENGTH+1)'(DEPTH - 2);
  localparam logic [ADDR_LENGTH:0] C_M3   = (ADDR_LENGTH+1)'(DEPTH - 3);
  localparam logic [ADDR_LENGTH:0] C_HALF = (ADDR_LENGTH+1)'(DEPTH / 2);
  localparam logic [ADDR_LENGTH:0] C_ONE  = (ADDR_LENGTH+1)'(1);

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_LENGTH-1:0] r_wptr, r_rptr;
  logic [ADDR_LENGTH:0]   r_count;
  logic w_flush, w_full, w_empty, w_wallow, w_rallow;

  assign w_flush  = ~reset_n | bus.clear_in;
  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  assign w_wallow = bus.wenable_in & ~w_full;
  assign w_rallow = bus.renable_in & ~w_empty;

  assign bus.wallow_out       = w_wallow;
  assign bus.rallow_out       = w_rallow;
  assign bus.waddr_out        = r_wptr;
  assign bus.raddr_out        = r_rptr;
  assign bus.full_out         = w_full;
  assign bus.empty_out        = w_empty;
  assign bus.almost_full_out  = (r_count == C_M1);
  assign bus.almost_empty_out = (r_count == C_ONE);
  assign bus.half_full_out    = (r_count >= C_HALF);
  assign bus.three_left_out   = (r_count == C_M3);
  assign bus.two_left_out     = (r_count == C_M2);

  // Async read port: old data is returned when writing the same address this cycle.
  assign bus.rdata_out = r_mem[r_rptr];

  always_ff @(posedge CLK) begin
    if (w_wallow && !w_flush) r_mem[r_wptr] <= bus.wdata_in;
  end

  // Full vs empty is told apart by count, so pointers wrap freely.
  always_ff @(posedge CLK) begin
    if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wallow) r_wptr <= r_wptr + 1'b1;
      if (w_rallow) r_rptr <= r_rptr + 1'b1;
      case ({w_wallow, w_rallow})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge CLK) begin
    if (w_flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wenable_in & w_full)  r_overflow  <= 1'b1;
      if (bus.renable_in & w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow_out  = r_overflow;
  assign bus.underflow_out = r_underflow;
`endif
endmodule

// File: tb/tb_fifo_ctrl_tpram.sv
// Randomized scoreboard bench for fifo_ctrl_tpram: a queue model tracks contents,
// a negedge monitor checks flags/pointers and pops expected words on rallow_out.
module tb_fifo_ctrl_tpram;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic CLK = 1'b0;
  logic reset_n;
  always #5 CLK = ~CLK;

  fifo_ctrl_tpram_if #(.ADDR_LENGTH(AW), .DATA_WIDTH(DW)) bus ();

  fifo_ctrl_tpram #(.ADDR_LENGTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: FIFO contents as a queue, pointers as modulo counters.
  logic [DW-1:0] mdl [$];
  logic [DW-1:0] sb  [$];
  logic [AW-1:0] m_wp, m_rp;
  logic          m_ovf, m_unf;
  bit            mon_en = 0;
  int            errs = 0;
  int            checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the model by what that edge should do.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                       input logic clr, input logic rn);
    bit wa, ra;
    bus.wenable_in = we;
    bus.wdata_in   = wd;
    bus.renable_in = re;
    bus.clear_in   = clr;
    reset_n        = rn;
    @(negedge CLK);
    @(posedge CLK);
    if (!rn || clr) begin
      mdl.delete(); sb.delete();
      m_wp = '0; m_rp = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      wa = we && (mdl.size() < DEPTH);
      ra = re && (mdl.size() > 0);
      if (we && mdl.size() == DEPTH) m_ovf = 1'b1;
      if (re && mdl.size() == 0)     m_unf = 1'b1;
      if (ra) begin void'(mdl.pop_front()); m_rp = m_rp + 1'b1; end
      if (wa) begin mdl.push_back(wd); sb.push_back(wd); m_wp = m_wp + 1'b1; end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      int n;
      n = mdl.size();
      chk("wallow",       64'(bus.wallow_out),       64'(bus.wenable_in && n < DEPTH));
      chk("rallow",       64'(bus.rallow_out),       64'(bus.renable_in && n > 0));
      chk("empty",        64'(bus.empty_out),        64'(n == 0));
      chk("full",         64'(bus.full_out),         64'(n == DEPTH));
      chk("almost_empty", 64'(bus.almost_empty_out), 64'(n == 1));
      chk("almost_full",  64'(bus.almost_full_out),  64'(n == DEPTH - 1));
      chk("half_full",    64'(bus.half_full_out),    64'(n >= DEPTH / 2));
      chk("three_left",   64'(bus.three_left_out),   64'(DEPTH - n == 3));
      chk("two_left",     64'(bus.two_left_out),     64'(DEPTH - n == 2));
      chk("waddr",        64'(bus.waddr_out),        64'(m_wp));
      chk("raddr",        64'(bus.raddr_out),        64'(m_rp));
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow",     64'(bus.overflow_out),     64'(m_ovf));
      chk("underflow",    64'(bus.underflow_out),    64'(m_unf));
`endif
      if (bus.rallow_out === 1'b1) begin
        if (sb.size() == 0) chk("rdata_no_expected", 64'(1), 64'(0));
        else                chk("rdata", 64'(bus.rdata_out), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_wp = '0; m_rp = '0; m_ovf = 1'b0; m_unf = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    mon_en = 1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);   // reset state observed here
    idle();

    // Single word: FWFT visibility, then pop.
    cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1);
    idle();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);   // read while empty is ignored

    // Fill to full with 0..31, then a dropped 33rd write.
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
    idle();
    // Full: write+read together only reads.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    // Drain to 5, then simultaneous read+write holds count.
    while (mdl.size() > 5) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h5000_0000 + DW'(i), 1'b1, 1'b0, 1'b1);
    while (mdl.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Fill 20 / drain 20 / fill 20 / drain 20 to wrap pointers.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end

    // Clear, then reset, each with 10 entries and a concurrent write.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, $urandom, 1'b0, (k == 0), (k != 0));
      idle();
    end

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 200) % 2 == 0) ? 75 : 35;
      rp = ((i / 200) % 2 == 0) ? 35 : 75;
      cycle(($urandom_range(99) < wp), $urandom, ($urandom_range(99) < rp),
            ($urandom_range(299) == 0), ($urandom_range(499) != 0));
    end
    idle();
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl_tpram.md
Name: fifo_ctrl_tpram

Overview:
- Single-clock synchronous FIFO: pointer/flag control plus a two-port RAM, packaged as one block.
- Write side is loaded word-by-word by the bus-master behavioural model; read side sources write data onto the ADIO bus.
- Read data is first-word-fall-through: the word at the read pointer is always visible on rdata_out.

Parameters:
- ADDR_LENGTH, 5: address width; depth DEPTH = 2**ADDR_LENGTH (32 entries).
- DATA_WIDTH, 32: word width.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clear_in  in  1  synchronous, active-high flush; same effect as reset on pointers, count and flags.
- wenable_in  in  1  write request.
- wdata_in  in  DATA_WIDTH  write data.
- renable_in  in  1  read request (pop).
- rdata_out  out  DATA_WIDTH  RAM word at raddr_out (combinational).
- wallow_out  out  1  write accepted this cycle.
- rallow_out  out  1  read accepted this cycle.
- waddr_out  out  ADDR_LENGTH  write pointer.
- raddr_out  out  ADDR_LENGTH  read pointer.
- full_out  out  1  count == DEPTH.
- almost_full_out  out  1  count == DEPTH-1.
- empty_out  out  1  count == 0.
- almost_empty_out  out  1  count == 1.
- half_full_out  out  1  count >= DEPTH/2.
- three_left_out  out  1  free slots == 3 (count == DEPTH-3).
- two_left_out  out  1  free slots == 2 (count == DEPTH-2).

Behaviour:
- Internal state: wptr and rptr, ADDR_LENGTH bits each; count, ADDR_LENGTH+1 bits, range 0..DEPTH.
- All flags decode combinationally from count; no extra latency.
- Reset (reset_n=0 at an edge) or clear_in=1: wptr=0, rptr=0, count=0.
  - Resulting outputs: empty_out=1; all other flags 0; waddr_out=raddr_out=0.
  - Overrides any simultaneous read or write. Reset mid-burst discards the contents.
- RAM contents are not reset or cleared; rdata_out is undefined until the first write.
- wallow_out = wenable_in & ~full_out (combinational).
  - On wallow: mem[wptr] <= wdata_in; wptr increments modulo DEPTH.
- rallow_out = renable_in & ~empty_out (combinational).
  - On rallow: rptr increments modulo DEPTH; rdata_out shows the next word in the same cycle as the pointer update.
- Count update per cycle:
  - +1 on wallow only; -1 on rallow only.
  - Unchanged when both or neither occur; with both, both pointers advance.
- Full boundary: a write while full is dropped even if a read is accepted in the same cycle; pointer and RAM are untouched.
- Empty boundary: a read while empty is ignored even if a write occurs in the same cycle. A written word appears on rdata_out the cycle after it is written.
- Pointer wrap: 31 -> 0 with no flag glitch; full is distinguished from empty by count, not by pointer equality.
- RAM is two-port:
  - Port A: synchronous write at waddr_out.
  - Port B: asynchronous read at raddr_out.
  - A same-address write and read in one cycle returns the old data that cycle.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, adds two outputs:
  - overflow_out: sticky 1, set on wenable_in & full_out.
  - underflow_out: sticky 1, set on renable_in & empty_out.
- Both flags clear only on reset or clear_in and have reset value 0.
- When undefined, the ports are absent and everything else is identical.

Test Plan:
- Reset -> empty_out=1, full_out=0, waddr_out=raddr_out=0.
- Write 0xA5A5_0001 (one cycle wenable_in) -> empty_out=0, almost_empty_out=1, next cycle rdata_out=0xA5A5_0001. Pulse renable_in -> empty_out=1, raddr_out=1.
- Write 32 words 0..31 -> after 16 writes half_full_out=1; at 29 three_left_out=1, 30 two_left_out=1, 31 almost_full_out=1, 32 full_out=1. A 33rd write gives wallow_out=0 and waddr_out stays 0 (with FIFO_ERR_FLAGS_EN, overflow_out=1).
- With the FIFO full, assert wenable_in and renable_in together -> rallow_out=1, wallow_out=0, count becomes 31. From count 5, simultaneous read+write leaves count at 5 and both pointers advance.
- Fill 20, drain 20, write 20 again -> pointers wrap past 31; words read back in order with correct data.
- Assert clear_in with count 10 and wenable_in=1 -> next cycle count=0, empty_out=1, pointers 0. Repeat the same with reset_n=0.
